// File: rtl/aes_round_sequencer.sv
// -----------------------------------------------------------------------------
// aes_round_sequencer
//
// Control sequencer for an iterative AES encryption core. Holds the 128-bit
// cipher state and steers an external, purely combinational round datapath
// (sub_bytes / shift_rows / mix_cols / add_round_key) one round per cycle.
// Rounds advance only when the key expander flags the requested round key as
// available.
//
// Block flow: IDLE -> INIT (round 0, key add only) -> ROUND (1..Nr-1, full
// round) -> FINAL (round Nr, no mix_cols) -> OUT (hold ciphertext until taken).
//
// Optional feature (macro AES_SEQ_ABORT_EN):
//   adds input 'abort'. Any non-IDLE state returns to IDLE on the next edge,
//   the state register is cleared and no ciphertext / done is produced.
//   Abort wins over key_valid and out_ready in the same cycle.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   key_size        00=AES-128 (10 rds), 01=AES-192 (12), 10=AES-256 (14),
//                   11=illegal (runs 10 rounds, sets sticky cfg_err)
//   in_valid/ready  plaintext handshake, data_in = plaintext
//   round_in        datapath result computed from state_out
//   key_valid       round key for key_idx available this cycle
//   key_idx         round key index requested from the key expander
//   round_idx       current round number
//   state_out       current state register (datapath operand)
//   *_en            per-step datapath enables
//   out_valid/ready ciphertext handshake, data_out zero while not valid
//   busy            high whenever not IDLE
//   done            one-cycle pulse on the output handshake
//   cfg_err         sticky illegal-key-size flag, cleared only by rst
//   abort           (AES_SEQ_ABORT_EN only) drop the block in flight
// -----------------------------------------------------------------------------
module aes_round_sequencer #(
  parameter int DATA_W     = 128,
  parameter int MAX_ROUNDS = 14,
  parameter int RIDX_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        key_size,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] round_in,
  input  logic              key_valid,
  output logic [RIDX_W-1:0] key_idx,
  output logic [RIDX_W-1:0] round_idx,
  output logic [DATA_W-1:0] state_out,
  output logic              sub_bytes_en,
  output logic              shift_rows_en,
  output logic              mix_cols_en,
  output logic              add_key_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
`ifdef AES_SEQ_ABORT_EN
  ,
  input  logic              abort
`endif
);

  // Elaboration-time parameter sanity.
  if (DATA_W != 128) begin : g_bad_data_w
    $error("aes_round_sequencer: DATA_W must be 128");
  end
  if (MAX_ROUNDS < 14) begin : g_bad_max_rounds
    $error("aes_round_sequencer: MAX_ROUNDS must cover AES-256 (14)");
  end
  if ((1 << RIDX_W) <= MAX_ROUNDS) begin : g_bad_ridx_w
    $error("aes_round_sequencer: RIDX_W too narrow for MAX_ROUNDS");
  end

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_ROUND = 3'd2;
  localparam logic [2:0] S_FINAL = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  logic [2:0]        fsm;
  logic [DATA_W-1:0] state_reg;
  logic [RIDX_W-1:0] ridx;
  logic [RIDX_W-1:0] ridx_inc;
  logic [RIDX_W-1:0] nr_q;
  logic              cfg_err_q;
  logic              abort_req;

  // Round count for a key size; the illegal code falls back to AES-128 so the
  // block still completes deterministically.
  function automatic logic [RIDX_W-1:0] rounds_for(input logic [1:0] ks);
    case (ks)
      2'b01:   return RIDX_W'(12);
      2'b10:   return RIDX_W'(14);
      default: return RIDX_W'(10);
    endcase
  endfunction

`ifdef AES_SEQ_ABORT_EN
  assign abort_req = abort && (fsm != S_IDLE);
`else
  assign abort_req = 1'b0;
`endif

  assign ridx_inc = ridx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= S_IDLE;
      state_reg <= '0;
      ridx      <= '0;
      nr_q      <= RIDX_W'(10);
      cfg_err_q <= 1'b0;
    end else if (abort_req) begin
      fsm       <= S_IDLE;
      state_reg <= '0;
      ridx      <= '0;
    end else begin
      case (fsm)
        S_IDLE: begin
          if (in_valid) begin
            state_reg <= data_in;
            nr_q      <= rounds_for(key_size);
            ridx      <= '0;
            fsm       <= S_INIT;
            if (key_size == 2'b11) cfg_err_q <= 1'b1;
          end
        end
        S_INIT: begin
          if (key_valid) begin
            state_reg <= round_in;
            ridx      <= RIDX_W'(1);
            fsm       <= S_ROUND;
          end
        end
        S_ROUND: begin
          // The last full round hands over to FINAL once the index
          // reaches Nr; round_idx then names the final round.
          if (key_valid) begin
            state_reg <= round_in;
            ridx      <= ridx_inc;
            if (ridx_inc == nr_q) fsm <= S_FINAL;
          end
        end
        S_FINAL: begin
          if (key_valid) begin
            state_reg <= round_in;
            fsm       <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            ridx <= '0;
            fsm  <= S_IDLE;
          end
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

  // Datapath steering: enables and key index follow the state directly so the
  // external round logic sees them in the same cycle as state_out.
  always_comb begin
    sub_bytes_en  = 1'b0;
    shift_rows_en = 1'b0;
    mix_cols_en   = 1'b0;
    add_key_en    = 1'b0;
    key_idx       = '0;
    case (fsm)
      S_INIT: begin
        add_key_en = 1'b1;
      end
      S_ROUND: begin
        sub_bytes_en  = 1'b1;
        shift_rows_en = 1'b1;
        mix_cols_en   = 1'b1;
        add_key_en    = 1'b1;
        key_idx       = ridx;
      end
      S_FINAL: begin
        sub_bytes_en  = 1'b1;
        shift_rows_en = 1'b1;
        add_key_en    = 1'b1;
        key_idx       = nr_q;
      end
      default: ;
    endcase
  end

  // in_ready is held low during reset so nothing is taken before release.
  assign in_ready  = (fsm == S_IDLE) && !rst;
  assign busy      = (fsm != S_IDLE);
  assign out_valid = (fsm == S_OUT) && !abort_req;
  assign done      = out_valid && out_ready;
  assign data_out  = out_valid ? state_reg : '0;
  assign state_out = state_reg;
  assign round_idx = ridx;
  assign cfg_err   = cfg_err_q;

  a_ridx_bound: assert property (@(posedge clk) disable iff (rst)
    round_idx <= nr_q);
  a_done_hs: assert property (@(posedge clk) disable iff (rst)
    done |-> (out_valid && out_ready));
  a_round_nonzero: assert property (@(posedge clk) disable iff (rst)
    (fsm == S_ROUND) |-> (round_idx != '0));

endmodule

// File: tb/tb_aes_round_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for aes_round_sequencer. The bench supplies the combinational AES
// round datapath and the round-key schedule, drives FIPS-197 and random
// blocks, and scores ciphertexts against a whole-block AES reference.
// -----------------------------------------------------------------------------
module tb_aes_round_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   key_size;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic [127:0] round_in;
  logic         key_valid;
  logic [3:0]   key_idx;
  logic [3:0]   round_idx;
  logic [127:0] state_out;
  logic         sub_bytes_en, shift_rows_en, mix_cols_en, add_key_en;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;
  logic         busy, done, cfg_err;
`ifdef AES_SEQ_ABORT_EN
  logic         abort;
`endif

  aes_round_sequencer #(.DATA_W(128), .MAX_ROUNDS(14), .RIDX_W(4)) dut (
    .clk(clk), .rst(rst), .key_size(key_size),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .round_in(round_in), .key_valid(key_valid), .key_idx(key_idx),
    .round_idx(round_idx), .state_out(state_out),
    .sub_bytes_en(sub_bytes_en), .shift_rows_en(shift_rows_en),
    .mix_cols_en(mix_cols_en), .add_key_en(add_key_en),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .busy(busy), .done(done), .cfg_err(cfg_err)
`ifdef AES_SEQ_ABORT_EN
    , .abort(abort)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- AES reference arithmetic ----------------
  logic [7:0] sbox_t [256];
  logic [15:0][127:0] rk_sched = '0;
  int cur_nr = 10;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox_t[s[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                           xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return o;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic int nk_of(input logic [1:0] ks);
    return (ks == 2'b01) ? 6 : (ks == 2'b10) ? 8 : 4;
  endfunction

  function automatic int nr_of(input logic [1:0] ks);
    return (ks == 2'b01) ? 12 : (ks == 2'b10) ? 14 : 10;
  endfunction

  // Key material is left-aligned in 256 bits (AES-128 uses the top 128).
  function automatic logic [15:0][127:0] expand(input logic [255:0] key, input logic [1:0] ks);
    logic [31:0] w [64];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [15:0][127:0] r;
    int nk, nr;
    nk = nk_of(ks); nr = nr_of(ks); rc = 8'h01; r = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int j = 0; j <= nr; j++) r[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    return r;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [255:0] key,
                                           input logic [1:0] ks);
    logic [15:0][127:0] k;
    logic [127:0] s;
    int nr;
    k = expand(key, ks); nr = nr_of(ks);
    s = pt ^ k[0];
    for (int r = 1; r < nr; r++) s = mix_cols(shift_rows(sub_bytes(s))) ^ k[r];
    return shift_rows(sub_bytes(s)) ^ k[nr];
  endfunction

  // External round datapath as seen by the sequencer.
  always_comb begin
    logic [127:0] s;
    s = state_out;
    if (sub_bytes_en)  s = sub_bytes(s);
    if (shift_rows_en) s = shift_rows(s);
    if (mix_cols_en)   s = mix_cols(s);
    if (add_key_en)    s = s ^ rk_sched[key_idx];
    round_in = s;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [127:0] ct;
    int           t_acc;
    int           lat;    // -1: latency not checked (random stalls)
  } exp_t;
  exp_t sb[$];

  logic         prev_ov = 1'b0, prev_or = 1'b0;
  logic [127:0] prev_do = '0;
  int           t_first = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) t_first = cyc;
      if (!out_valid) check("data_out_idle_zero", data_out, 128'h0);
      if (out_valid && prev_ov && !prev_or) check("data_out_hold", data_out, prev_do);
      check("done_on_handshake", done, out_valid && out_ready);
      check("in_ready_vs_busy", in_ready, !busy);
      if (sub_bytes_en) check("mix_cols_en_round", mix_cols_en, key_idx != cur_nr);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 1'b1, 1'b0);
        end else begin
          e = sb.pop_front();
          check("ciphertext", data_out, e.ct);
          if (e.lat >= 0) check("latency", t_first - e.t_acc, e.lat);
        end
      end
      prev_ov = out_valid; prev_or = out_ready; prev_do = data_out;
    end
  end

  // ---------------- driver ----------------
  bit rand_kv = 0, rand_or = 0;

  task tick();
    @(posedge clk); #1;
    if (rand_kv) key_valid = ($urandom_range(3) != 0);
    if (rand_or) out_ready = ($urandom_range(2) != 0);
  endtask

  task automatic send(input logic [127:0] pt, input logic [255:0] key, input logic [1:0] ks,
                      input logic [127:0] ct, input int lat);
    exp_t e;
    int n;
    n = 0;
    while (!in_ready && n < 300) begin tick(); n++; end
    if (!in_ready) check("in_ready_timeout", in_ready, 1'b1);
    rk_sched = expand(key, ks);
    cur_nr   = nr_of(ks);
    data_in  = pt; key_size = ks; in_valid = 1'b1;
    e.ct = ct; e.t_acc = cyc; e.lat = lat;
    sb.push_back(e);
    tick();
    in_valid = 1'b0;
    data_in  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_ridx(input int k);
    int n;
    n = 0;
    while (round_idx != 4'(k) && n < 100) begin tick(); n++; end
    check("wait_round_idx", round_idx, k);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 1000) begin tick(); n++; end
    check("drain", sb.size(), 0);
  endtask

  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] st, d0, pt;
    logic [255:0] key;
    logic [1:0]   ks;
    logic [7:0]   inv;

    rst = 1'b1; in_valid = 1'b0; key_valid = 1'b1; out_ready = 1'b1;
    data_in = '0; key_size = 2'b00;
`ifdef AES_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    for (int b = 0; b < 256; b++) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, 8'(b));
      sbox_t[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_cfg_err", cfg_err, 1'b0);
    check("rst_state_out", state_out, 128'h0);
    check("rst_round_idx", round_idx, 4'h0);
    check("rst_enables", {sub_bytes_en, shift_rows_en, mix_cols_en, add_key_en}, 4'h0);
    tick();

    // FIPS-197 C.1 and C.3 with the key always ready
    send(PT, K128, 2'b00, CT128, 12);
    wait_idle();
    send(PT, K256, 2'b10, CT256, 16);
    wait_idle();

    // key stall in round 5
    send(PT, K128, 2'b00, CT128, 15);
    wait_ridx(5);
    key_valid = 1'b0;
    st = state_out;
    repeat (3) begin
      tick();
      check("stall_round_idx", round_idx, 4'd5);
      check("stall_state_out", state_out, st);
      check("stall_enables", {sub_bytes_en, mix_cols_en}, 2'b11);
    end
    key_valid = 1'b1;
    wait_idle();

    // output back-pressure for 4 cycles
    out_ready = 1'b0;
    pt = {$urandom, $urandom, $urandom, $urandom};
    key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    send(pt, key, 2'b01, aes_ref(pt, key, 2'b01), 14);
    for (int n = 0; n < 100 && !out_valid; n++) tick();
    check("hold_out_valid", out_valid, 1'b1);
    d0 = data_out;
    repeat (4) begin
      check("hold_in_ready", in_ready, 1'b0);
      check("hold_done", done, 1'b0);
      check("hold_data", data_out, d0);
      tick();
    end
    out_ready = 1'b1;
    #1 check("hs_done", done, 1'b1);
    tick();
    check("post_hs_done", done, 1'b0);
    check("post_hs_in_ready", in_ready, 1'b1);
    check("post_hs_out_valid", out_valid, 1'b0);

    // illegal key size runs as AES-128 and latches cfg_err
    send(PT, K128, 2'b11, CT128, 12);
    wait_idle();
    check("cfg_err_set", cfg_err, 1'b1);
    pt = {$urandom, $urandom, $urandom, $urandom};
    send(pt, K128, 2'b00, aes_ref(pt, K128, 2'b00), 12);
    wait_idle();
    check("cfg_err_sticky", cfg_err, 1'b1);

    // randomized blocks, key stalls and back-pressure
    rand_kv = 1; rand_or = 1;
    for (int b = 0; b < 40; b++) begin
      ks  = 2'($urandom_range(3));
      pt  = {$urandom, $urandom, $urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      repeat ($urandom_range(2)) tick();
      send(pt, key, ks, aes_ref(pt, key, ks), -1);
    end
    wait_idle();
    rand_kv = 0; rand_or = 0; key_valid = 1'b1; out_ready = 1'b1;
    tick();

`ifdef AES_SEQ_ABORT_EN
    // abort in round 7 drops the block
    send(PT, K128, 2'b00, CT128, -1);
    wait_ridx(7);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    sb.delete();
    check("abort_busy", busy, 1'b0);
    check("abort_state_out", state_out, 128'h0);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_done", done, 1'b0);
    repeat (16) begin
      tick();
      check("abort_no_output", out_valid, 1'b0);
    end
    send(PT, K128, 2'b00, CT128, 12);
    wait_idle();
`endif

    // asynchronous reset in round 7
    send(PT, K128, 2'b00, CT128, -1);
    wait_ridx(7);
    #2 rst = 1'b1;
    sb.delete();
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_state_out", state_out, 128'h0);
    check("arst_round_idx", round_idx, 4'h0);
    check("arst_enables", {sub_bytes_en, shift_rows_en, mix_cols_en, add_key_en}, 4'h0);
    check("arst_cfg_err_clear", cfg_err, 1'b0);
    tick();
    rst = 1'b0;
    repeat (20) begin
      tick();
      check("arst_no_output", out_valid, 1'b0);
    end
    check("arst_in_ready", in_ready, 1'b1);

    wait_idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
